// File: rtl/pong_pkg.sv
// Shared types and default timing constants for the pong switch conditioner.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM_P = 3'd1,
    HELD  = 3'd2,
    ARM_R = 3'd3,
    LOCK  = 3'd4
  } btn_state_t;

  localparam int DEF_DEB_CYCLES  = 16;
  localparam int DEF_LOCK_CYCLES = 64;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pong_btn_cond_if.sv
// Switch-side and game-FSM-side signals of the pong button conditioner.
interface pong_btn_cond_if;
  logic btn_r_raw;
  logic btn_l_raw;
  logic en;
  logic hit_r;
  logic hit_l;
  logic lvl_r;
  logic lvl_l;
  logic both;

  // master: the side that owns the switches and consumes the pulses
  modport master (
    output btn_r_raw, btn_l_raw, en,
    input  hit_r, hit_l, lvl_r, lvl_l, both
  );

  modport slave (
    input  btn_r_raw, btn_l_raw, en,
    output hit_r, hit_l, lvl_r, lvl_l, both
  );
endinterface

// File: rtl/pong_btn_chan.sv
// One switch channel: 2-flop synchronizer, debounce/lockout FSM, registered
// level and single-cycle hit pulse.
module pong_btn_chan
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic en_i,
  output logic hit_o,
  output logic lvl_o
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  btn_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hit_pend_q;
  logic             hit_q;
  logic             lvl_q;

  // Outputs are one stage behind the state so hit and lvl rise together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      hit_pend_q <= 1'b0;
      hit_q      <= 1'b0;
      lvl_q      <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      hit_pend_q <= 1'b0;
      hit_q      <= hit_pend_q;
      lvl_q      <= (state_q == HELD) || (state_q == ARM_R);

      case (state_q)
        IDLE: begin
          if (sync2_q) begin
            state_q <= ARM_P;
            cnt_q   <= CNT_ONE;
          end
        end
        ARM_P: begin
          if (!sync2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q    <= HELD;
            cnt_q      <= '0;
            // en is sampled only here; a press accepted while disabled is lost
            hit_pend_q <= en_i;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync2_q) begin
            state_q <= ARM_R;
            cnt_q   <= CNT_ONE;
          end
        end
        ARM_R: begin
          if (sync2_q) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q <= LOCK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        LOCK: begin
          if (cnt_q == LOCK_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign hit_o = hit_q;
  assign lvl_o = lvl_q;

endmodule

// File: rtl/pong_btn_cond.sv
// Two-player switch conditioner: independent right/left channels feeding the
// game FSM with debounced levels, hit pulses and a coincidence flag.
module pong_btn_cond
  import pong_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  pong_btn_cond_if.slave bus
);

  // index 0 = right player, index 1 = left player
  logic [1:0] raw;
  logic [1:0] hit;
  logic [1:0] lvl;

  assign raw = {bus.btn_l_raw, bus.btn_r_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      pong_btn_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .CNT_W       (CNT_W)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .raw_i (raw[gi]),
        .en_i  (bus.en),
        .hit_o (hit[gi]),
        .lvl_o (lvl[gi])
      );
    end
  endgenerate

  // No arbitration here; the game FSM decides who wins a tie.
  assign bus.hit_r = hit[0];
  assign bus.hit_l = hit[1];
  assign bus.lvl_r = lvl[0];
  assign bus.lvl_l = lvl[1];
  assign bus.both  = hit[0] & hit[1];

endmodule
